// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state encodings and default board, paddle,
// score and serve constants.
package pong_pkg;

    localparam int unsigned C_GAME_WIDTH    = 40;
    localparam int unsigned C_GAME_HEIGHT   = 30;
    localparam int unsigned C_PADDLE_HEIGHT = 6;
    localparam int unsigned C_SCORE_LIMIT   = 9;
    localparam int unsigned C_SERVE_FRAMES  = 60;

    localparam int unsigned TILE_W  = 6;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'b000,
        ST_RUNNING = 3'b001,
        ST_P1_WINS = 3'b010,
        ST_P2_WINS = 3'b011,
        ST_CLEANUP = 3'b100
    } state_e;

endpackage

// File: rtl/button_edge.sv
// Registered rising-edge detector for a synchronous button level.
// Ports: i_clk, i_rst (async active-high), i_btn level in, o_rise one-cycle
// registered pulse on each low-to-high transition of i_btn.
module button_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_rise
);

    logic level_q;
    logic rise_q;

    // level_q resets high so a button already held through reset must be
    // seen low before it can produce an event.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            level_q <= 1'b1;
            rise_q  <= 1'b0;
        end else begin
            level_q <= i_btn;
            rise_q  <= i_btn & ~level_q;
        end
    end

    assign o_rise = rise_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: start handling, miss detection, scoring, win and
// serve-delay sequencing.
// Ports: i_clk, i_rst (async active-high), i_game_start level,
// i_frame_tick pulse, ball and paddle tile positions in; o_game_active,
// scores, win flags and FSM state out (all registered).
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned c_game_width    = C_GAME_WIDTH,
    parameter int unsigned c_game_height   = C_GAME_HEIGHT,
    parameter int unsigned c_paddle_height = C_PADDLE_HEIGHT,
    parameter int unsigned c_score_limit   = C_SCORE_LIMIT,
    parameter int unsigned c_serve_frames  = C_SERVE_FRAMES
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_game_start,
    input  logic               i_frame_tick,
    input  logic [TILE_W-1:0]  i_ball_x,
    input  logic [TILE_W-1:0]  i_ball_y,
    input  logic [TILE_W-1:0]  i_paddle_y_p1,
    input  logic [TILE_W-1:0]  i_paddle_y_p2,
    output logic               o_game_active,
    output logic [SCORE_W-1:0] o_p1_score,
    output logic [SCORE_W-1:0] o_p2_score,
    output logic               o_p1_wins,
    output logic               o_p2_wins,
    output logic [STATE_W-1:0] o_state
);

    localparam int unsigned ROW_W = TILE_W + 1;
    localparam int unsigned CNT_W = 6;

    logic               start_evt;
    state_e             state_q, state_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic [SCORE_W-1:0] score_inc_c;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               p1_miss_c, p2_miss_c;
    logic               p1_miss_q, p2_miss_q;
    logic               game_active_q, p1_wins_q, p2_wins_q;

    button_edge u_start_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn  (i_game_start),
        .o_rise (start_evt)
    );

    // Row test uses a 7-bit paddle bottom so paddles near row 63 don't wrap.
    always_comb begin
        p1_miss_c = (i_ball_x == TILE_W'(0)) &&
                    (({1'b0, i_ball_y} < {1'b0, i_paddle_y_p1}) ||
                     ({1'b0, i_ball_y} > ({1'b0, i_paddle_y_p1} +
                                          ROW_W'(c_paddle_height) - ROW_W'(1))));
        p2_miss_c = (i_ball_x == TILE_W'(c_game_width - 1)) &&
                    (({1'b0, i_ball_y} < {1'b0, i_paddle_y_p2}) ||
                     ({1'b0, i_ball_y} > ({1'b0, i_paddle_y_p2} +
                                          ROW_W'(c_paddle_height) - ROW_W'(1))));
    end

    // State register, miss pipeline and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            p1_score_q    <= '0;
            p2_score_q    <= '0;
            frame_cnt_q   <= '0;
            p1_miss_q     <= 1'b0;
            p2_miss_q     <= 1'b0;
            game_active_q <= 1'b0;
            p1_wins_q     <= 1'b0;
            p2_wins_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            p1_score_q    <= p1_score_d;
            p2_score_q    <= p2_score_d;
            frame_cnt_q   <= frame_cnt_d;
            p1_miss_q     <= p1_miss_c;
            p2_miss_q     <= p2_miss_c;
            game_active_q <= (state_d == ST_RUNNING);
            p1_wins_q     <= (state_d == ST_P1_WINS);
            p2_wins_q     <= (state_d == ST_P2_WINS);
        end
    end

    // Next-state, scoring and serve counter.
    always_comb begin
        state_d     = state_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        frame_cnt_d = '0;
        score_inc_c = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_evt) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                // P1 miss wins the tie; scores saturate at the limit.
                if (p1_miss_q) begin
                    score_inc_c = (p2_score_q < SCORE_W'(c_score_limit)) ?
                                  p2_score_q + SCORE_W'(1) : p2_score_q;
                    p2_score_d  = score_inc_c;
                    state_d     = (score_inc_c == SCORE_W'(c_score_limit)) ?
                                  ST_P2_WINS : ST_CLEANUP;
                end else if (p2_miss_q) begin
                    score_inc_c = (p1_score_q < SCORE_W'(c_score_limit)) ?
                                  p1_score_q + SCORE_W'(1) : p1_score_q;
                    p1_score_d  = score_inc_c;
                    state_d     = (score_inc_c == SCORE_W'(c_score_limit)) ?
                                  ST_P1_WINS : ST_CLEANUP;
                end
            end
            ST_CLEANUP: begin
                frame_cnt_d = frame_cnt_q;
                if (i_frame_tick) begin
                    if (frame_cnt_q + CNT_W'(1) == CNT_W'(c_serve_frames)) begin
                        frame_cnt_d = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_P1_WINS, ST_P2_WINS: begin
                if (start_evt) begin
                    p1_score_d = '0;
                    p2_score_d = '0;
                    state_d    = ST_CLEANUP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_game_active = game_active_q;
    assign o_p1_score    = p1_score_q;
    assign o_p2_score    = p2_score_q;
    assign o_p1_wins     = p1_wins_q;
    assign o_p2_wins     = p2_wins_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl (serve delay of 3 frames).
module tb_pong_game_ctrl;
    import pong_pkg::*;

    logic       clk, rst, start, ftick;
    logic [5:0] bx, by, p1y, p2y;
    logic       active, p1w, p2w;
    logic [3:0] p1s, p2s;
    logic [2:0] st;

    int total = 0;
    int bad   = 0;
    int m_p1  = 0;
    int m_p2  = 0;
    bit running = 0;

    pong_game_ctrl #(.c_serve_frames(3)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_game_start  (start),
        .i_frame_tick  (ftick),
        .i_ball_x      (bx),
        .i_ball_y      (by),
        .i_paddle_y_p1 (p1y),
        .i_paddle_y_p2 (p2y),
        .o_game_active (active),
        .o_p1_score    (p1s),
        .o_p2_score    (p2s),
        .o_p1_wins     (p1w),
        .o_p2_wins     (p2w),
        .o_state       (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int bx; int by; int p1y; int p2y;
        int st; int d1; int d2;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic safe_ball();
        bx = 6'd20; by = 6'd15; p1y = 6'd10; p2y = 6'd10;
    endtask

    task automatic press_start();
        start = 1'b1; tick();
        start = 1'b0; tick();
    endtask

    task automatic frame();
        ftick = 1'b1; tick();
        ftick = 1'b0; tick();
    endtask

    // Scores one non-winning point for the chosen player and returns to IDLE.
    task automatic score_point(input bit p1_scores);
        if (!running) press_start();
        if (p1_scores) begin bx = 6'd39; by = 6'd0; end
        else           begin bx = 6'd0;  by = 6'd0; end
        tick(); tick(); tick();
        if (p1_scores) m_p1++; else m_p2++;
        safe_ball();
        repeat (3) frame();
        running = 0;
        check("point p1", int'(p1s), m_p1);
        check("point p2", int'(p2s), m_p2);
        check("point idle", int'(st), int'(ST_IDLE));
    endtask

    vec_t vec[12];

    initial begin
        vec[0]  = '{0, 12, 10, 10, int'(ST_RUNNING), 0, 0};
        vec[1]  = '{0, 10, 10, 10, int'(ST_RUNNING), 0, 0};
        vec[2]  = '{0, 15, 10, 10, int'(ST_RUNNING), 0, 0};
        vec[3]  = '{0, 16, 10, 10, int'(ST_CLEANUP), 0, 1};
        vec[4]  = '{39, 9, 10, 10, int'(ST_CLEANUP), 1, 0};
        vec[5]  = '{39, 15, 10, 10, int'(ST_RUNNING), 0, 0};
        vec[6]  = '{20, 0, 10, 10, int'(ST_RUNNING), 0, 0};
        vec[7]  = '{0, 9, 10, 10, int'(ST_CLEANUP), 0, 1};
        vec[8]  = '{0, 63, 60, 10, int'(ST_RUNNING), 0, 0};
        vec[9]  = '{38, 0, 10, 10, int'(ST_RUNNING), 0, 0};
        vec[10] = '{39, 0, 10, 0, int'(ST_RUNNING), 0, 0};
        vec[11] = '{39, 6, 10, 0, int'(ST_CLEANUP), 1, 0};

        rst = 1'b1; start = 1'b0; ftick = 1'b0;
        safe_ball();
        #12;
        check("rst state", int'(st), 0);
        check("rst active", int'(active), 0);
        check("rst p1", int'(p1s), 0);
        check("rst p2", int'(p2s), 0);
        check("rst wins", int'({p1w, p2w}), 0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Start pulse: event register, then RUNNING on the following edge.
        start = 1'b1; tick();
        check("start evt cycle", int'(st), int'(ST_IDLE));
        start = 1'b0; tick();
        check("start running", int'(st), int'(ST_RUNNING));
        check("start active", int'(active), 1);
        running = 1;

        // Start ignored while running; ticks ignored while running.
        press_start();
        check("start ignored", int'(st), int'(ST_RUNNING));

        // Ball inside paddle rows held at column 0 for 100 cycles.
        bx = 6'd0; by = 6'd12; p1y = 6'd10;
        for (int i = 0; i < 100; i++) begin
            ftick = (i % 10 == 0);
            tick();
        end
        ftick = 1'b0;
        check("hold p2", int'(p2s), 0);
        check("hold state", int'(st), int'(ST_RUNNING));

        // Miss: registered detect, then score/state/active together.
        by = 6'd20;
        tick();
        check("miss lat state", int'(st), int'(ST_RUNNING));
        check("miss lat active", int'(active), 1);
        tick();
        check("miss state", int'(st), int'(ST_CLEANUP));
        check("miss active", int'(active), 0);
        check("miss p2", int'(p2s), 1);
        m_p2 = 1;
        repeat (50) tick();
        check("miss once", int'(p2s), 1);
        safe_ball();

        // Serve delay: IDLE on the third tick.
        frame(); frame();
        check("serve 2 ticks", int'(st), int'(ST_CLEANUP));
        frame();
        check("serve 3 ticks", int'(st), int'(ST_IDLE));
        running = 0;
        frame();
        check("tick in idle", int'(st), int'(ST_IDLE));

        // Table-driven miss/no-miss vectors.
        for (int i = 0; i < 12; i++) begin
            if (!running) begin press_start(); running = 1; end
            bx = 6'(vec[i].bx); by = 6'(vec[i].by);
            p1y = 6'(vec[i].p1y); p2y = 6'(vec[i].p2y);
            tick(); tick(); tick();
            m_p1 += vec[i].d1;
            m_p2 += vec[i].d2;
            check($sformatf("vec%0d state", i), int'(st), vec[i].st);
            check($sformatf("vec%0d p1", i), int'(p1s), m_p1);
            check($sformatf("vec%0d p2", i), int'(p2s), m_p2);
            safe_ball();
            if (vec[i].st == int'(ST_CLEANUP)) begin
                repeat (3) frame();
                check($sformatf("vec%0d idle", i), int'(st), int'(ST_IDLE));
                running = 0;
            end
        end
        if (running) begin
            score_point(1'b0);
        end

        // P1 reaches the limit.
        while (m_p1 < 8) score_point(1'b1);
        press_start();
        bx = 6'd39; by = 6'd0; p2y = 6'd10;
        tick(); tick(); tick();
        check("win state", int'(st), int'(ST_P1_WINS));
        check("win p1", int'(p1s), 9);
        check("win flag", int'(p1w), 1);
        check("win p2 flag", int'(p2w), 0);
        check("win active", int'(active), 0);
        check("win p2", int'(p2s), m_p2);
        repeat (20) tick();
        check("win sat", int'(p1s), 9);
        safe_ball();
        press_start();
        check("clear state", int'(st), int'(ST_CLEANUP));
        check("clear p1", int'(p1s), 0);
        check("clear p2", int'(p2s), 0);
        check("clear flag", int'(p1w), 0);
        m_p1 = 0; m_p2 = 0;
        repeat (3) frame();
        check("clear idle", int'(st), int'(ST_IDLE));
        running = 0;

        // Async reset mid-RUNNING with scores 3/5.
        repeat (3) score_point(1'b1);
        repeat (5) score_point(1'b0);
        press_start();
        check("pre-rst state", int'(st), int'(ST_RUNNING));
        #3 rst = 1'b1;
        #1;
        check("async state", int'(st), 0);
        check("async active", int'(active), 0);
        check("async p1", int'(p1s), 0);
        check("async p2", int'(p2s), 0);
        check("async wins", int'({p1w, p2w}), 0);

        // Start held through reset release produces no event.
        start = 1'b1;
        tick();
        @(negedge clk) rst = 1'b0;
        repeat (4) tick();
        check("held start idle", int'(st), int'(ST_IDLE));
        start = 1'b0; tick();
        press_start();
        check("repress running", int'(st), int'(ST_RUNNING));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
